six_bits_operand_collector: RTL and testbench
=============================================

# six_bits_operand_collector

Upstream feeder for the four-input 6-bit adder. Accepts a serial stream of 6-bit words over a valid/ready handshake and groups every four consecutive words into one operand set a, b, c, d, plus a carry-in. Presents each set on a held valid/ready output port that drives the adder's a/b/c/d/cin inputs. A one-group staging buffer lets the next group be collected while the current one is held.

## Interface
Parameters:
- none; operand width fixed at 6, group size fixed at 4.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- clr  in  1  synchronous clear of the partial group and the staged group
- in_valid  in  1  in_data/in_cin/in_last valid
- in_ready  out  1  collector can accept a word this cycle
- in_data  in  6  operand word
- in_cin  in  1  carry-in; sampled only with the first word of a group
- in_last  in  1  early end of group (used only with the macro)
- out_valid  out  1  operand set on a/b/c/d/cin is valid
- out_ready  in  1  adder side consumes the set
- a, b, c, d  out  6 each  operands: group words 1, 2, 3, 4
- cin  out  1  carry-in captured with word 1

## Operation
- Word accepted on a rising edge with in_valid && in_ready.
- Slot counter 0..3 selects the destination: slot 0 -> a (plus in_cin), 1 -> b, 2 -> c, 3 -> d.
- Counter increments per accepted word and wraps 3 -> 0 on group completion.
- Group completion (slot 3 accepted):
  - Output register empty, or draining at the same edge (out_valid && out_ready): the full group loads into the output register and out_valid = 1.
  - Otherwise: the group stays in staging and staging_full = 1.
- in_ready = !staging_full && !clr; combinational.
- Output drain with staging_full = 1: the staging group transfers to the output register at the same edge. out_valid stays 1 and staging_full clears.
- Output drain with no staged group and no group completing: out_valid clears.
- a/b/c/d/cin hold their values until out_valid && out_ready; they change only on a load.
- clr:
  - Zeroes the slot counter and discards partial and staged words; staging_full = 0.
  - in_ready is 0 for that cycle, so no word is accepted.
  - The output register and out_valid are unaffected.
- No arithmetic is performed; words pass through bit-exact.

## Timing
- Reset values (while rst_n low): out_valid 0, a = b = c = d = 0, cin 0, counter 0, staging_full 0, in_ready 1 (clr low).
- Latency: 4th word accepted at edge N -> out_valid = 1 after edge N (visible in cycle N+1), when the output is free.
- Throughput: one group per 4 accepted words, with no bubbles when out_ready is held high.
- Backpressure: in_ready stays 1 until a second complete group exists while the first is still unconsumed. It drops to 0 in the cycle after that group completes, and returns to 1 the cycle after the output drains.
- Simultaneous clr and drain: the drain completes normally; the staged group is discarded, not transferred.
- Reset mid-group or mid-hold: all state returns to reset values immediately; partial data is lost.

## Configuration
- SIX_BITS_COLLECT_ZERO_PAD_EN defined:
  - in_last accepted on slot k < 3 completes the group immediately.
  - Slots k+1..3 load 0; completion and hand-off proceed exactly as for a slot-3 word.
  - in_last on slot 3 is a no-op.
- Not defined:
  - in_last is ignored; groups always contain 4 words.

## Test plan
- Reset, then stream 5, 10, 20, 63 with in_cin=1 on word 1 and out_ready=1 -> next cycle: out_valid=1, a=5, b=10, c=20, d=63, cin=1; out_valid=0 the cycle after.
- Stream 8 words back-to-back (1..8) with out_ready=0 -> set {1,2,3,4} held. After word 8, in_ready=0. Raise out_ready -> {1,2,3,4} then {5,6,7,8} on consecutive cycles; in_ready returns to 1.
- Accept 2 words, assert clr for 1 cycle, then stream 9, 9, 9, 9 -> a=b=c=d=9; cleared words never appear.
- Assert rst_n=0 mid-hold with out_valid=1 -> out_valid=0 and a..d=0 immediately; the first group after release is formed from fresh words only.
- With SIX_BITS_COLLECT_ZERO_PAD_EN: words 7, 3 with in_last on word 2 -> a=7, b=3, c=0, d=0, out_valid=1 next cycle. Without the macro, the same stimulus produces no output until 2 more words arrive.

Source files
------------

// File: rtl/six_bits_operand_collector.sv
// Groups four 6-bit words (+cin with word 1) into a/b/c/d for the 4-input adder; optional SIX_BITS_COLLECT_ZERO_PAD_EN zero-pads short groups.
// Latency: group visible the cycle after its last word is accepted when the output is free.
// Backpressure: one staged group absorbs a held output; in_ready drops only when staging is full.
module six_bits_operand_collector (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] in_data,
    input  logic       in_cin,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] a,
    output logic [5:0] b,
    output logic [5:0] c,
    output logic [5:0] d,
    output logic       cin
);

    logic [1:0] cnt;
    logic       staging_full;
    logic [5:0] stg [0:3];
    logic       stg_cin;

    logic [5:0] grp [0:3];
    logic       grp_cin;
    logic       acc;
    logic       early;
    logic       cmpl;
    logic       drain;

    assign in_ready = !staging_full && !clr;

`ifdef SIX_BITS_COLLECT_ZERO_PAD_EN
    assign early = in_last;
`else
    logic unused_last;
    assign unused_last = in_last;
    assign early       = 1'b0;
`endif

    // grp is the staging buffer with this cycle's word merged in, i.e. the group as it stands after the edge
    always_comb begin
        acc     = in_valid && in_ready;
        drain   = out_valid && out_ready;
        cmpl    = acc && ((cnt == 2'd3) || early);
        grp_cin = (acc && (cnt == 2'd0)) ? in_cin : stg_cin;
        for (int j = 0; j < 4; j++) begin
            grp[j] = stg[j];
            if (acc && (cnt == 2'(j)))
                grp[j] = in_data;
            if (acc && early && (2'(j) > cnt))
                grp[j] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            staging_full <= 1'b0;
            stg_cin      <= 1'b0;
            for (int j = 0; j < 4; j++)
                stg[j] <= '0;
            out_valid    <= 1'b0;
            a            <= '0;
            b            <= '0;
            c            <= '0;
            d            <= '0;
            cin          <= 1'b0;
        end else begin
            if (acc) begin
                for (int j = 0; j < 4; j++)
                    stg[j] <= grp[j];
                stg_cin <= grp_cin;
                cnt     <= cmpl ? 2'd0 : cnt + 2'd1;
            end

            // staging_full and cmpl are mutually exclusive: in_ready is low while staged
            if (staging_full && drain && !clr) begin
                a            <= stg[0];
                b            <= stg[1];
                c            <= stg[2];
                d            <= stg[3];
                cin          <= stg_cin;
                staging_full <= 1'b0;
            end else if (cmpl && (!out_valid || drain)) begin
                a         <= grp[0];
                b         <= grp[1];
                c         <= grp[2];
                d         <= grp[3];
                cin       <= grp_cin;
                out_valid <= 1'b1;
            end else begin
                if (cmpl)
                    staging_full <= 1'b1;
                if (drain)
                    out_valid <= 1'b0;
            end

            if (clr) begin
                cnt          <= '0;
                staging_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_six_bits_operand_collector.sv
module tb_six_bits_operand_collector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] in_data = '0;
    logic       in_cin = 1'b0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [5:0] a, b, c, d;
    logic       cin;

    int n_chk  = 0;
    int n_fail = 0;

    six_bits_operand_collector dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_cin(in_cin), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .c(c), .d(d), .cin(cin)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [24:0] g(input int ci, input int w0, input int w1, input int w2, input int w3);
        return {ci[0], w0[5:0], w1[5:0], w2[5:0], w3[5:0]};
    endfunction

    function automatic logic [24:0] outv();
        return {cin, a, b, c, d};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic        clr;
        logic        vld;
        logic [5:0]  dat;
        logic        ci;
        logic        ordy;
        logic        erdy;
        logic        eov;
        logic [24:0] eout;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic cl, input logic v, input int dt, input logic ci,
                                input logic ordy, input logic erdy, input logic eov, input logic [24:0] eo);
        vec_t r;
        r.clr = cl; r.vld = v; r.dat = dt[5:0]; r.ci = ci; r.ordy = ordy;
        r.erdy = erdy; r.eov = eov; r.eout = eo;
        return r;
    endfunction

    // ---------------- reference model ----------------
    logic [6:0]  part[$];
    logic [24:0] m_stage, m_out;
    bit          m_sf, m_ov;

    task automatic model_reset();
        part.delete();
        m_stage = '0; m_out = '0; m_sf = 0; m_ov = 0;
    endtask

    // Called just after a rising edge with the inputs that were sampled at it
    task automatic model_step();
        bit          m_rdy, accw, done, drn, pad;
        logic [24:0] grpv;
        logic [5:0]  w [4];
        m_rdy = !m_sf && !clr;
        accw  = in_valid && m_rdy;
        drn   = m_ov && out_ready;
        done  = 0;
        grpv  = '0;
`ifdef SIX_BITS_COLLECT_ZERO_PAD_EN
        pad = in_last;
`else
        pad = 0;
`endif
        if (accw) begin
            part.push_back({in_cin, in_data});
            if (part.size() == 4 || pad) begin
                for (int i = 0; i < 4; i++)
                    w[i] = (i < part.size()) ? part[i][5:0] : 6'd0;
                grpv = {part[0][6], w[0], w[1], w[2], w[3]};
                part.delete();
                done = 1;
            end
        end
        if (clr) part.delete();
        if (drn) begin
            if (m_sf && !clr) begin
                m_out = m_stage; m_sf = 0;
            end else if (done) begin
                m_out = grpv;
            end else begin
                m_ov = 0;
            end
        end else if (done) begin
            if (!m_ov) begin
                m_out = grpv; m_ov = 1;
            end else begin
                m_stage = grpv; m_sf = 1;
            end
        end
        if (clr) m_sf = 0;
    endtask

    task automatic send(input int dt, input logic ci, input logic lst);
        in_valid = 1'b1; in_data = dt[5:0]; in_cin = ci; in_last = lst;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; in_cin = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [24:0] h0, h1, h5, h9;
        h0 = g(1, 5, 10, 20, 63);
        h1 = g(0, 1, 2, 3, 4);
        h5 = g(0, 5, 6, 7, 8);
        h9 = g(0, 9, 9, 9, 9);

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", outv(), '0);
        @(posedge clk); #1 rst_n = 1'b1;

        //          clr  vld dat ci  ordy erdy eov  expected a..d/cin
        tbl.push_back(mk(0, 1, 5,  1, 1, 1, 0, '0));
        tbl.push_back(mk(0, 1, 10, 0, 1, 1, 0, '0));
        tbl.push_back(mk(0, 1, 20, 0, 1, 1, 0, '0));
        tbl.push_back(mk(0, 1, 63, 0, 1, 1, 0, '0));
        tbl.push_back(mk(0, 0, 0,  0, 1, 1, 1, h0));
        tbl.push_back(mk(0, 0, 0,  0, 0, 1, 0, h0));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(0, 1, i, 0, 0, 1, 0, h0));
        for (int i = 5; i <= 8; i++)
            tbl.push_back(mk(0, 1, i, 0, 0, 1, 1, h1));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 1, h1));
        tbl.push_back(mk(0, 0, 0,  0, 1, 0, 1, h1));
        tbl.push_back(mk(0, 0, 0,  0, 1, 1, 1, h5));
        tbl.push_back(mk(0, 0, 0,  0, 0, 1, 0, h5));
        tbl.push_back(mk(0, 1, 11, 0, 1, 1, 0, h5));
        tbl.push_back(mk(0, 1, 12, 0, 1, 1, 0, h5));
        tbl.push_back(mk(1, 1, 13, 0, 1, 0, 0, h5));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 1, 9, 0, 1, 1, 0, h5));
        tbl.push_back(mk(0, 0, 0,  0, 1, 1, 1, h9));
        tbl.push_back(mk(0, 0, 0,  0, 1, 1, 0, h9));

        foreach (tbl[k]) begin
            clr = tbl[k].clr; in_valid = tbl[k].vld; in_data = tbl[k].dat;
            in_cin = tbl[k].ci; in_last = 1'b0; out_ready = tbl[k].ordy;
            @(negedge clk);
            chk($sformatf("tbl%0d_in_ready", k), in_ready, tbl[k].erdy);
            chk($sformatf("tbl%0d_out_valid", k), out_valid, tbl[k].eov);
            chk($sformatf("tbl%0d_out_data", k), outv(), tbl[k].eout);
            @(posedge clk); #1;
        end
        clr = 1'b0; in_valid = 1'b0;

        // reset mid-hold
        do_reset();
        out_ready = 1'b0;
        send(33, 1, 0); send(34, 0, 0); send(35, 0, 0); send(36, 0, 0);
        send(37, 0, 0);
        @(negedge clk);
        chk("hold_out_valid", out_valid, 1);
        chk("hold_out_data", outv(), g(1, 33, 34, 35, 36));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_out_data", outv(), '0);
        chk("async_rst_in_ready", in_ready, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        out_ready = 1'b1;
        send(10, 0, 0); send(20, 0, 0); send(30, 0, 0); send(40, 0, 0);
        @(negedge clk);
        chk("post_rst_out_valid", out_valid, 1);
        chk("post_rst_out_data", outv(), g(0, 10, 20, 30, 40));
        @(posedge clk); #1;

        // clr together with a drain while a group is staged
        out_ready = 1'b0;
        for (int i = 21; i <= 28; i++) send(i, 0, 0);
        @(negedge clk);
        chk("staged_in_ready", in_ready, 0);
        @(posedge clk); #1;
        clr = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        chk("clr_drain_out_valid", out_valid, 0);
        chk("clr_drain_out_data", outv(), g(0, 21, 22, 23, 24));
        chk("clr_drain_in_ready", in_ready, 1);

        // early in_last
        @(posedge clk); #1;
        send(7, 0, 0); send(3, 0, 1);
        @(negedge clk);
`ifdef SIX_BITS_COLLECT_ZERO_PAD_EN
        chk("pad_out_valid", out_valid, 1);
        chk("pad_out_data", outv(), g(0, 7, 3, 0, 0));
        @(posedge clk); #1;
`else
        chk("nopad_out_valid", out_valid, 0);
        @(posedge clk); #1;
        send(50, 0, 0); send(51, 0, 0);
        @(negedge clk);
        chk("nopad_out_valid_late", out_valid, 1);
        chk("nopad_out_data", outv(), g(0, 7, 3, 50, 51));
        @(posedge clk); #1;
`endif

        // randomized run against the model
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 6'($urandom);
            in_cin    = 1'($urandom);
            in_last   = ($urandom_range(0, 5) == 0);
            clr       = ($urandom_range(0, 24) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            chk("rand_in_ready", in_ready, (!m_sf && !clr));
            chk("rand_out_valid", out_valid, m_ov);
            chk("rand_out_data", outv(), m_out);
            @(posedge clk);
            model_step();
            #1;
        end
        clr = 1'b0; in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
